mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and result width; only 32 is supported.
REQ-002 The block SHALL have parameter ITER, default 32: iterations per operation, equal to WIDTH.
REQ-003 The block SHALL have port Clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start_mult, input, 1 bit: request signed multiply of A by B; sampled in IDLE only.
REQ-006 The block SHALL have port start_div, input, 1 bit: request signed divide of A by B; sampled in IDLE only.
REQ-007 The block SHALL have port A, input, 32 bits: rs operand, two's complement.
REQ-008 The block SHALL have port B, input, 32 bits: rt operand, two's complement.
REQ-009 The block SHALL have port busy, output, 1 bit: high in MULT, DIV and DONE states.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse, high while HI/LO first show a new result.
REQ-011 The block SHALL have port div_zero, output, 1 bit: one-cycle pulse flagging a divide-by-zero request.
REQ-012 The block SHALL have port HI, output, 32 bits: product upper word, or remainder.
REQ-013 The block SHALL have port LO, output, 32 bits: product lower word, or quotient.

Function
REQ-014 The FSM SHALL have states IDLE, MULT, DIV and DONE.
REQ-015 In IDLE, with start_mult=1 in cycle 0, the block SHALL latch |A|, |B| and both signs and enter MULT in cycle 1.
REQ-016 In IDLE, with start_div=1 and B!=0 in cycle 0, the block SHALL latch operands likewise and enter DIV in cycle 1.
REQ-017 When start_mult and start_div are both 1 in IDLE, multiply SHALL win and the divide request SHALL be dropped.
REQ-018 When start_div=1 and B==0 in IDLE, the block SHALL pulse div_zero in cycle 1, stay in IDLE with busy=0, and leave HI/LO unchanged.
REQ-019 MULT SHALL run an unsigned shift-add on the magnitudes, one bit per cycle, for exactly ITER cycles (cycles 1..32).
REQ-020 DIV SHALL run an unsigned restoring shift-subtract on the magnitudes, one bit per cycle, for exactly ITER cycles (cycles 1..32).
REQ-021 At the end of cycle 32 the block SHALL apply sign correction and load HI/LO.
  - Product: negated if the operand signs differ.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the sign of A (truncating division).
REQ-022 DONE SHALL last exactly one cycle (cycle 33), with done=1 and the new HI/LO visible; cycle 34 SHALL be IDLE.
REQ-023 Total latency SHALL be 33 cycles from the start cycle to done, independent of operand values.
REQ-024 The 64-bit product SHALL be exact; -2^31 / -1 SHALL give LO=0x80000000 and HI=0 (wrap, no flag).
REQ-025 start_mult and start_div SHALL be ignored while busy=1; no queuing.
REQ-026 HI/LO SHALL hold their previous values during MULT/DIV; working registers SHALL be separate from HI/LO.
REQ-027 done and div_zero SHALL never be high in the same cycle.

Reset
REQ-028 When Reset=1 at a clock edge, the next state SHALL be IDLE with busy=0, done=0, div_zero=0, HI=0, LO=0 and the iteration counter at 0.
REQ-029 Reset during MULT/DIV/DONE SHALL abort the operation with no done pulse and no partial result on HI/LO.
REQ-030 Reset SHALL take priority over simultaneous start_mult/start_div.

Structure
REQ-031 Shared package mult_div_pkg SHALL hold the state enum (IDLE, MULT, DIV, DONE) and the constant ITER=32.
REQ-032 One sub-module, mult_div_step, SHALL implement the combinational single-bit shift-add / shift-subtract step; FSM, counter and sign handling stay in mult_div_ctrl.
REQ-033 The integration glue SHALL be as follows:
  - The control unit holds its state while busy=1.
  - MemtoReg selects HI or LO for mfhi/mflo.

Verification
REQ-034 A=7, B=-3, start_mult in cycle 0 -> done=1 in cycle 33, HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0 in cycle 34.
REQ-035 A=-7, B=2, start_div -> LO=0xFFFFFFFD, HI=0xFFFFFFFF at done (cycle 33).
REQ-036 A=5, B=0, start_div with HI/LO preloaded to 0x11/0x22 -> div_zero=1 in cycle 1 only, busy=0 throughout, HI/LO still 0x11/0x22.
REQ-037 A=B=0x80000000, start_mult -> HI=0x40000000, LO=0x00000000 at cycle 33.
REQ-038 start_mult (A=100, B=10), then start_div asserted in cycle 10 -> divide ignored, single done in cycle 33, HI=0, LO=1000.
REQ-039 start_div (A=100, B=7), then Reset=1 in cycle 15 -> cycle 16 is IDLE with busy=0 and HI=LO=0, no done pulse afterwards.

Source files
------------

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit.
//   state_e : controller FSM states
//   ITER    : shift iterations per operation (one result bit per cycle)
package mult_div_pkg;

    localparam int unsigned ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : mult_div_pkg

// File: rtl/mult_div_step.sv
// One iteration of the unsigned magnitude datapath (purely combinational).
//   is_div   : 0 = shift-add multiply step, 1 = restoring shift-subtract divide step
//   acc_hi   : multiply partial product high word / divide partial remainder
//   acc_lo   : multiply remaining multiplier bits / divide dividend-quotient word
//   operand  : multiplicand (multiply) or divisor (divide) magnitude
//   hi_c     : next acc_hi
//   lo_c     : next acc_lo
module mult_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    logic [WIDTH:0]   sum_c;      // multiply: partial product plus carry-out
    logic [WIDTH:0]   shifted_c;  // divide: remainder shifted left with next dividend bit
    logic             fits_c;     // divide: divisor fits into the shifted remainder
    logic [WIDTH-1:0] trial_c;    // divide: shifted remainder minus divisor

    // Datapath for both operations
    always_comb begin
        sum_c     = {1'b0, acc_hi};
        shifted_c = {acc_hi, acc_lo[WIDTH-1]};
        fits_c    = (shifted_c >= {1'b0, operand});
        // Remainder stays below the divisor, so the difference always fits in WIDTH bits
        trial_c   = shifted_c[WIDTH-1:0] - operand;
        hi_c      = acc_hi;
        lo_c      = acc_lo;

        if (is_div) begin
            hi_c = fits_c ? trial_c : shifted_c[WIDTH-1:0];
            lo_c = {acc_lo[WIDTH-2:0], fits_c};
        end else begin
            if (acc_lo[0]) begin
                sum_c = {1'b0, acc_hi} + {1'b0, operand};
            end
            // Shift the whole {carry, hi, lo} register right by one
            hi_c = sum_c[WIDTH:1];
            lo_c = {sum_c[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule : mult_div_step

// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide controller with HI/LO result registers.
// Operates on magnitudes for ITER cycles, then sign-corrects into HI/LO.
//   Clk, Reset            : clock, synchronous active-high reset
//   start_mult, start_div : operation requests, honoured only when idle
//   A, B                  : signed operands (rs, rt)
//   busy                  : operation in progress (MULT, DIV, DONE)
//   done                  : one-cycle pulse when a new result appears on HI/LO
//   div_zero              : one-cycle pulse for a rejected divide by zero
//   HI, LO                : product high/low word, or remainder/quotient
module mult_div_ctrl
    import mult_div_pkg::state_e;
    import mult_div_pkg::IDLE;
    import mult_div_pkg::MULT;
    import mult_div_pkg::DIV;
    import mult_div_pkg::DONE;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = mult_div_pkg::ITER
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CNT_W  = $clog2(ITER);
    localparam int unsigned PROD_W = 2 * WIDTH;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   acc_hi_q,   acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q,   acc_lo_d;
    logic [WIDTH-1:0]   opnd_q,     opnd_d;
    logic               sign_a_q,   sign_a_d;
    logic               sign_b_q,   sign_b_d;
    logic [WIDTH-1:0]   hi_q,       hi_d;
    logic [WIDTH-1:0]   lo_q,       lo_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   mag_a_c;
    logic [WIDTH-1:0]   mag_b_c;
    logic [WIDTH-1:0]   step_hi_c;
    logic [WIDTH-1:0]   step_lo_c;
    logic [PROD_W-1:0]  prod_c;
    logic [PROD_W-1:0]  prod_fix_c;
    logic [WIDTH-1:0]   quot_fix_c;
    logic [WIDTH-1:0]   rem_fix_c;

    // Operand magnitudes; -2^31 maps to 0x80000000, which is correct unsigned
    always_comb begin
        mag_a_c = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
        mag_b_c = B[WIDTH-1] ? (WIDTH'(0) - B) : B;
    end

    mult_div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .is_div  (state_q == DIV),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opnd_q),
        .hi_c    (step_hi_c),
        .lo_c    (step_lo_c)
    );

    // Sign correction applied to the final iteration's result
    always_comb begin
        prod_c     = {step_hi_c, step_lo_c};
        prod_fix_c = (sign_a_q ^ sign_b_q) ? (PROD_W'(0) - prod_c) : prod_c;
        quot_fix_c = (sign_a_q ^ sign_b_q) ? (WIDTH'(0) - step_lo_c) : step_lo_c;
        rem_fix_c  = sign_a_q ? (WIDTH'(0) - step_hi_c) : step_hi_c;
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Multiply wins over a simultaneous divide request
                if (start_mult) begin
                    state_d  = MULT;
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = mag_b_c;
                    opnd_d   = mag_a_c;
                    sign_a_d = A[WIDTH-1];
                    sign_b_d = B[WIDTH-1];
                end else if (start_div) begin
                    if (B == '0) begin
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = DIV;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        acc_lo_d = mag_a_c;
                        opnd_d   = mag_b_c;
                        sign_a_d = A[WIDTH-1];
                        sign_b_d = B[WIDTH-1];
                    end
                end
            end
            MULT, DIV: begin
                acc_hi_d = step_hi_c;
                acc_lo_d = step_lo_c;
                cnt_d    = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (state_q == MULT) begin
                        hi_d = prod_fix_c[PROD_W-1:WIDTH];
                        lo_d = prod_fix_c[WIDTH-1:0];
                    end else begin
                        hi_d = rem_fix_c;
                        lo_d = quot_fix_c;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign HI       = hi_q;
    assign LO       = lo_q;

endmodule : mult_div_ctrl

// File: tb/tb_mult_div_ctrl.sv
// Directed self-checking bench for mult_div_ctrl.
// Cycle 0 is the cycle in which a start request is presented; outputs are
// sampled 1 time unit after each rising edge.
module tb_mult_div_ctrl;

    logic        Clk;
    logic        Reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks;
    int n_fail;

    // Expected HI/LO currently held by the DUT, maintained by the bench
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mult_div_ctrl #(
        .WIDTH      (32),
        .ITER       (32)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .HI         (HI),
        .LO         (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Full operation from cycle 0 through cycle 34
    task automatic run_op(input string tag, input logic is_mult,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        start_mult = is_mult;
        start_div  = ~is_mult;
        A          = a;
        B          = b;
        tick();                                   // cycle 1
        start_mult = 1'b0;
        start_div  = 1'b0;
        check({tag, " busy_c1"}, 64'(busy), 64'(1'b1));
        repeat (31) tick();                       // cycle 32
        check({tag, " done_c32"}, 64'(done), 64'(1'b0));
        check({tag, " hold_c32"}, {HI, LO}, {exp_hi, exp_lo});
        tick();                                   // cycle 33
        check({tag, " done_c33"}, 64'(done), 64'(1'b1));
        check({tag, " busy_c33"}, 64'(busy), 64'(1'b1));
        check({tag, " dz_c33"}, 64'(div_zero), 64'(1'b0));
        check({tag, " hilo_c33"}, {HI, LO}, {ehi, elo});
        tick();                                   // cycle 34
        check({tag, " busy_c34"}, 64'(busy), 64'(1'b0));
        check({tag, " done_c34"}, 64'(done), 64'(1'b0));
        exp_hi = ehi;
        exp_lo = elo;
    endtask

    initial begin
        logic saw_done;
        n_checks   = 0;
        n_fail     = 0;
        exp_hi     = 32'h0;
        exp_lo     = 32'h0;

        // Reset wins over a simultaneous start
        Reset      = 1'b1;
        start_mult = 1'b1;
        start_div  = 1'b0;
        A          = 32'd1;
        B          = 32'd1;
        tick();
        tick();
        check("reset busy", 64'(busy), 64'(1'b0));
        check("reset done", 64'(done), 64'(1'b0));
        check("reset div_zero", 64'(div_zero), 64'(1'b0));
        check("reset hilo", {HI, LO}, 64'h0);
        Reset      = 1'b0;
        start_mult = 1'b0;
        tick();
        check("idle after reset busy", 64'(busy), 64'(1'b0));

        // 7 * -3 = -21
        run_op("mul 7*-3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // -7 / 2 = -3 rem -1
        run_op("div -7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // 100 / -7 = -14 rem 2
        run_op("div 100/-7", 1'b0, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2);
        // -2^31 * -2^31 = 2^62
        run_op("mul min*min", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        // -2^31 / -1 wraps to -2^31, remainder 0
        run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        // Preload HI/LO = 0x11/0x22: 102 * 0x2AAAAAAB = 0x00000011_00000022
        run_op("mul preload", 1'b1, 32'd102, 32'h2AAA_AAAB, 32'h11, 32'h22);

        // Divide by zero: pulse in cycle 1 only, never busy, HI/LO untouched
        start_div = 1'b1;
        A         = 32'd5;
        B         = 32'd0;
        check("dz busy_c0", 64'(busy), 64'(1'b0));
        tick();
        start_div = 1'b0;
        check("dz div_zero_c1", 64'(div_zero), 64'(1'b1));
        check("dz busy_c1", 64'(busy), 64'(1'b0));
        check("dz done_c1", 64'(done), 64'(1'b0));
        check("dz hilo_c1", {HI, LO}, 64'h0000_0011_0000_0022);
        tick();
        check("dz div_zero_c2", 64'(div_zero), 64'(1'b0));
        check("dz busy_c2", 64'(busy), 64'(1'b0));
        check("dz hilo_c2", {HI, LO}, 64'h0000_0011_0000_0022);

        // Both starts together: multiply 6*3 wins (divide would give 2 rem 0)
        start_mult = 1'b1;
        start_div  = 1'b1;
        A          = 32'd6;
        B          = 32'd3;
        tick();
        start_mult = 1'b0;
        start_div  = 1'b0;
        repeat (32) tick();                       // cycle 33
        check("both done_c33", 64'(done), 64'(1'b1));
        check("both hilo_c33", {HI, LO}, 64'd18);
        tick();
        check("both busy_c34", 64'(busy), 64'(1'b0));
        exp_hi = 32'h0;
        exp_lo = 32'd18;

        // Divide request during a multiply is ignored
        start_mult = 1'b1;
        A          = 32'd100;
        B          = 32'd10;
        tick();                                   // cycle 1
        start_mult = 1'b0;
        repeat (9) tick();                        // cycle 10
        start_div  = 1'b1;
        B          = 32'd7;
        tick();                                   // cycle 11
        start_div  = 1'b0;
        repeat (21) tick();                       // cycle 32
        check("ignore done_c32", 64'(done), 64'(1'b0));
        check("ignore hold_c32", {HI, LO}, {exp_hi, exp_lo});
        tick();                                   // cycle 33
        check("ignore done_c33", 64'(done), 64'(1'b1));
        check("ignore hilo_c33", {HI, LO}, 64'd1000);
        saw_done = 1'b0;
        for (int i = 34; i <= 70; i++) begin
            tick();
            saw_done = saw_done | done | busy;
        end
        check("ignore no second op", 64'(saw_done), 64'(1'b0));
        exp_hi = 32'h0;
        exp_lo = 32'd1000;

        // Reset in the middle of a divide
        start_div = 1'b1;
        A         = 32'd100;
        B         = 32'd7;
        tick();                                   // cycle 1
        start_div = 1'b0;
        repeat (14) tick();                       // cycle 15
        check("abort busy_c15", 64'(busy), 64'(1'b1));
        check("abort hold_c15", {HI, LO}, {exp_hi, exp_lo});
        Reset = 1'b1;
        tick();                                   // cycle 16
        Reset = 1'b0;
        check("abort busy_c16", 64'(busy), 64'(1'b0));
        check("abort done_c16", 64'(done), 64'(1'b0));
        check("abort hilo_c16", {HI, LO}, 64'h0);
        saw_done = 1'b0;
        for (int i = 17; i <= 60; i++) begin
            tick();
            saw_done = saw_done | done;
        end
        check("abort no done", 64'(saw_done), 64'(1'b0));
        check("abort hilo_after", {HI, LO}, 64'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;

        // Recovery after abort: -100 / -7 = 14 rem -2
        run_op("div -100/-7", 1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_div_ctrl
